fp_norm_shift_seq: RTL and testbench
====================================

# fp_norm_shift_seq

Iterative significand normalizer for the IEEE-754 single-precision datapath, placed after the non-restoring divider quotient stage. It consumes a 24-bit significand and its biased exponent, finds the leading one and applies the left shift. The shift is resolved as a binary search: one stage per cycle, with stage sizes 16, 8, 4, 2 and 1. Outputs are the normalized significand, the adjusted exponent, the 5-bit shift count and status flags, all behind a valid/ready handshake.

## Interface
- MANT_W, 24, significand width (fixed at 24; stages sized for it)
- EXP_W, 8, biased exponent input width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand present
- in_ready  output  1  block can accept; high only in IDLE
- in_mant  input  24  unnormalized significand
- in_exp  input  8  biased exponent of in_mant
- out_valid  output  1  result present; held until accepted
- out_ready  input  1  consumer accepts result
- out_mant  output  24  normalized significand
- out_exp  output  10  signed two's-complement exponent after adjustment
- out_shift  output  5  total left shift applied (0..23)
- out_zero  output  1  in_mant was zero
- out_uflow  output  1  adjusted exponent < 1
- out_denorm  output  1  result is subnormal (only with NORM_DENORM_EN)

## Operation
- States: IDLE, SHIFT, DONE. The stage index k runs 4 down to 0.
- IDLE: in_ready=1. On in_valid&in_ready, latch the working registers:
  - m ← in_mant
  - e ← zero-extended in_exp
  - cnt ← 0
  - zero ← (in_mant==0)
- IDLE → SHIFT with k=4, or IDLE → DONE directly if zero.
- SHIFT, per cycle at stage k, let s = 2^k. When the shift condition holds:
  - m ← m<<s
  - e ← e−s
  - cnt[k] ← 1
  - Shift condition: the top s bits of m are all zero, plus the exponent condition under NORM_DENORM_EN.
- SHIFT sequencing: after k=0, go to DONE; otherwise k ← k−1.
- DONE:
  - out_valid=1; out_* driven from the working registers.
  - On out_ready, go to IDLE.
- Zero input result: out_mant=0, out_exp=0, out_shift=0, out_zero=1, out_uflow=0.
- Arithmetic: e is a 10-bit signed value, so e−cnt never wraps (range −23..255).
- out_uflow = (e < 1) && !zero.
- The nonzero-input invariant out_mant[23]=1 holds in DONE except in the denorm case.

## Timing
- Reset values: in_ready=0 during reset; after reset the state is IDLE, so in_ready=1. out_valid=0 and all out_* data = 0.
- Latency: accept at edge T → out_valid high after edge T+5 (5 SHIFT cycles). Zero input: out_valid high after edge T+1.
- out_* data is stable while out_valid=1 and out_ready=0.
- Output handshake at edge U → in_ready high after U. Minimum initiation interval is 7 cycles (nonzero input).
- in_valid is ignored outside IDLE. in_mant/in_exp are sampled only at the accept edge.
- Reset asserted mid-operation aborts immediately: state returns to IDLE, all outputs return to reset values, and no partial result is emitted.

## Configuration
- NORM_DENORM_EN defined:
  - The SHIFT condition additionally requires e − s ≥ 1, so the total shift is min(leading zeros, in_exp−1).
  - If in_exp = 0, no shift occurs.
  - In DONE, if m[23]=0 and !zero: out_denorm=1, out_exp=0, out_uflow=0.
- NORM_DENORM_EN undefined:
  - The shift is always the full leading-zero count.
  - out_denorm is tied to 0.
  - out_exp may be ≤0, and out_uflow flags it.

## Test plan
- in_mant=0x000001, in_exp=100 → after 5 cycles: out_mant=0x800000, out_shift=23, out_exp=77, uflow=0.
- in_mant=0x800000, in_exp=127 → out_shift=0, out_mant=0x800000, out_exp=127. in_mant=0x0F0000 → out_shift=4, out_mant=0xF00000, out_exp=123 (in_exp=127).
- in_mant=0, in_exp=50 → out_valid 1 cycle after accept: out_zero=1, out_mant=0, out_exp=0, out_shift=0.
- in_mant=0x000100, in_exp=5:
  - Without macro: out_shift=15, out_exp=−10 (0x3F6), uflow=1.
  - With NORM_DENORM_EN: out_shift=4, out_mant=0x001000, denorm=1, out_exp=0.
- Backpressure: hold out_ready=0 for 10 cycles → out_* constant and in_ready=0. Release it → in_ready=1 the next cycle, and a second operand is accepted back-to-back.
- Assert rst during SHIFT (k=2) → out_valid=0 and outputs zero. The next operand is processed correctly with no residue from the aborted one.

Source files
------------

// File: rtl/fp_norm_shift_seq.sv
// fp_norm_shift_seq: iterative significand normalizer for the single-precision
// divider path. A 24-bit significand is left-shifted until its leading one
// reaches bit 23, resolving the shift as a binary search of stages 16/8/4/2/1
// (one stage per cycle). The biased exponent is reduced by the shift amount.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   in_mant, in_exp       unnormalized significand and its biased exponent
//   out_valid / out_ready result handshake (result held until accepted)
//   out_mant              normalized significand
//   out_exp               10-bit two's-complement adjusted exponent
//   out_shift             total left shift applied
//   out_zero              input significand was zero
//   out_uflow             adjusted exponent below 1 (nonzero input)
//   out_denorm            result is subnormal (NORM_DENORM_EN only, else 0)
//
// Build option: define NORM_DENORM_EN to stop shifting once the exponent would
// fall below 1, producing a subnormal result instead of an underflowed one.
module fp_norm_shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_mant,
    input  logic [7:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_mant,
    output logic [9:0]  out_exp,
    output logic [4:0]  out_shift,
    output logic        out_zero,
    output logic        out_uflow,
    output logic        out_denorm
);

    localparam int unsigned MANT_W = 24;
    localparam int unsigned EXP_W  = 8;
    localparam int unsigned OEXP_W = 10;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned K_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [MANT_W-1:0]   m_q, m_d;
    logic [OEXP_W-1:0]   e_q, e_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                zero_q, zero_d;

    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [MANT_W-1:0]   out_mant_q, out_mant_d;
    logic [OEXP_W-1:0]   out_exp_q, out_exp_d;
    logic [CNT_W-1:0]    out_shift_q, out_shift_d;
    logic                out_zero_q, out_zero_d;
    logic                out_uflow_q, out_uflow_d;
    logic                out_denorm_q, out_denorm_d;

    // Current stage: shift size, leading-bit test and candidate exponent
    logic [CNT_W-1:0]    shift_amt;
    logic [CNT_W-1:0]    keep_bits;
    logic                top_zero;
    logic [OEXP_W-1:0]   e_shift;
    logic                do_shift;
    logic                load_out;
    logic                denorm_now;

    always_comb begin
        shift_amt = CNT_W'(1) << k_q;
        keep_bits = CNT_W'(MANT_W) - shift_amt;
        top_zero  = ((m_q >> keep_bits) == '0);
        e_shift   = e_q - OEXP_W'(shift_amt);
`ifdef NORM_DENORM_EN
        do_shift  = top_zero && ($signed(e_shift) >= 10'sd1);
`else
        do_shift  = top_zero;
`endif
    end

    // Next-state, working registers and output capture
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        m_d          = m_q;
        e_d          = e_q;
        cnt_d        = cnt_q;
        zero_d       = zero_q;
        load_out     = 1'b0;
        denorm_now   = 1'b0;
        out_valid_d  = out_valid_q;
        out_mant_d   = out_mant_q;
        out_exp_d    = out_exp_q;
        out_shift_d  = out_shift_q;
        out_zero_d   = out_zero_q;
        out_uflow_d  = out_uflow_q;
        out_denorm_d = out_denorm_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    m_d     = in_mant;
                    e_d     = {(OEXP_W-EXP_W)'(0), in_exp};
                    cnt_d   = '0;
                    zero_d  = (in_mant == '0);
                    k_d     = K_W'(4);
                    state_d = (in_mant == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (do_shift) begin
                    m_d        = m_q << shift_amt;
                    e_d        = e_shift;
                    cnt_d[k_q] = 1'b1;
                end
                if (k_q == '0) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end else begin
                    k_d = k_q - K_W'(1);
                end
            end
            DONE: begin
                // Zero operands arrive here straight from IDLE: publish one cycle later
                if (!out_valid_q) begin
                    load_out = 1'b1;
                end else if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_out) begin
`ifdef NORM_DENORM_EN
            denorm_now = !m_d[MANT_W-1] && !zero_d;
`endif
            out_valid_d  = 1'b1;
            out_mant_d   = m_d;
            out_exp_d    = (zero_d || denorm_now) ? '0 : e_d;
            out_shift_d  = cnt_d;
            out_zero_d   = zero_d;
            out_uflow_d  = !zero_d && !denorm_now && ($signed(e_d) < 10'sd1);
            out_denorm_d = denorm_now;
        end

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            m_q          <= '0;
            e_q          <= '0;
            cnt_q        <= '0;
            zero_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_mant_q   <= '0;
            out_exp_q    <= '0;
            out_shift_q  <= '0;
            out_zero_q   <= 1'b0;
            out_uflow_q  <= 1'b0;
            out_denorm_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            m_q          <= m_d;
            e_q          <= e_d;
            cnt_q        <= cnt_d;
            zero_q       <= zero_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_mant_q   <= out_mant_d;
            out_exp_q    <= out_exp_d;
            out_shift_q  <= out_shift_d;
            out_zero_q   <= out_zero_d;
            out_uflow_q  <= out_uflow_d;
            out_denorm_q <= out_denorm_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_mant   = out_mant_q;
    assign out_exp    = out_exp_q;
    assign out_shift  = out_shift_q;
    assign out_zero   = out_zero_q;
    assign out_uflow  = out_uflow_q;
    assign out_denorm = out_denorm_q;

endmodule

// File: tb/tb_fp_norm_shift_seq.sv
// Directed bench for fp_norm_shift_seq: reset values, full/no/partial shift,
// zero input, exponent underflow (or subnormal with NORM_DENORM_EN),
// backpressure with back-to-back issue, and reset abort mid-operation.
module tb_fp_norm_shift_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_mant;
    logic [7:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic [9:0]  out_exp;
    logic [4:0]  out_shift;
    logic        out_zero;
    logic        out_uflow;
    logic        out_denorm;

    int n_checks = 0;
    int n_errors = 0;

    fp_norm_shift_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mant    (in_mant),
        .in_exp     (in_exp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_exp    (out_exp),
        .out_shift  (out_shift),
        .out_zero   (out_zero),
        .out_uflow  (out_uflow),
        .out_denorm (out_denorm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand and wait (bounded) for the result; lat = -1 on timeout
    task automatic do_op(input logic [23:0] mant, input logic [7:0] exp, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        in_mant  = mant;
        in_exp   = exp;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_mant  = 24'hABCDEF;
        in_exp   = 8'hEE;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_checks++; if ({out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow, out_denorm} !== 44'd0) begin
            n_errors++; $display("FAIL rst_outputs: valid=%b mant=%h exp=%h shift=%0d want all 0", out_valid, out_mant, out_exp, out_shift); end
        #3 rst = 1'b0;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_full_shift();
        int lat;
        do_op(24'h000001, 8'd100, lat);
        n_checks++; if (lat !== 5) begin n_errors++; $display("FAIL full_latency: got %0d want 5", lat); end
        n_checks++; if (out_mant !== 24'h800000) begin n_errors++; $display("FAIL full_mant: got %h want 800000", out_mant); end
        n_checks++; if (out_shift !== 5'd23) begin n_errors++; $display("FAIL full_shift: got %0d want 23", out_shift); end
        n_checks++; if (out_exp !== 10'd77) begin n_errors++; $display("FAIL full_exp: got %0d want 77", out_exp); end
        n_checks++; if ({out_zero, out_uflow, out_denorm} !== 3'b000) begin
            n_errors++; $display("FAIL full_flags: got z%b u%b d%b want 000", out_zero, out_uflow, out_denorm); end
        ack();
    endtask

    task automatic test_no_shift();
        int lat;
        do_op(24'h800000, 8'd127, lat);
        n_checks++; if ({out_mant, out_exp, out_shift} !== {24'h800000, 10'd127, 5'd0}) begin
            n_errors++; $display("FAIL noshift_result: got mant=%h exp=%0d shift=%0d want 800000/127/0", out_mant, out_exp, out_shift); end
        ack();
        do_op(24'h0F0000, 8'd127, lat);
        n_checks++; if ({out_mant, out_exp, out_shift} !== {24'hF00000, 10'd123, 5'd4}) begin
            n_errors++; $display("FAIL shift4_result: got mant=%h exp=%0d shift=%0d want F00000/123/4", out_mant, out_exp, out_shift); end
        n_checks++; if (out_uflow !== 1'b0) begin n_errors++; $display("FAIL shift4_uflow: got %b want 0", out_uflow); end
        ack();
    endtask

    task automatic test_zero();
        int lat;
        do_op(24'h000000, 8'd50, lat);
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL zero_latency: got %0d want 1", lat); end
        n_checks++; if ({out_mant, out_exp, out_shift, out_zero, out_uflow, out_denorm} !== {24'h0, 10'd0, 5'd0, 3'b100}) begin
            n_errors++; $display("FAIL zero_result: got mant=%h exp=%h shift=%0d z%b u%b d%b", out_mant, out_exp, out_shift, out_zero, out_uflow, out_denorm); end
        ack();
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL zero_ready_after_ack: got %b want 1", in_ready); end
    endtask

    task automatic test_uflow();
        int lat;
        do_op(24'h000100, 8'd5, lat);
        n_checks++; if (lat !== 5) begin n_errors++; $display("FAIL uflow_latency: got %0d want 5", lat); end
`ifdef NORM_DENORM_EN
        n_checks++; if ({out_mant, out_exp, out_shift, out_uflow, out_denorm} !== {24'h001000, 10'd0, 5'd4, 2'b01}) begin
            n_errors++; $display("FAIL denorm_result: got mant=%h exp=%h shift=%0d u%b d%b want 001000/000/4/u0/d1", out_mant, out_exp, out_shift, out_uflow, out_denorm); end
        ack();
        do_op(24'h000100, 8'd0, lat);
        n_checks++; if ({out_mant, out_exp, out_shift, out_uflow, out_denorm} !== {24'h000100, 10'd0, 5'd0, 2'b01}) begin
            n_errors++; $display("FAIL denorm_exp0: got mant=%h exp=%h shift=%0d u%b d%b want 000100/000/0/u0/d1", out_mant, out_exp, out_shift, out_uflow, out_denorm); end
`else
        n_checks++; if ({out_mant, out_exp, out_shift, out_uflow, out_denorm} !== {24'h800000, 10'h3F6, 5'd15, 2'b10}) begin
            n_errors++; $display("FAIL uflow_result: got mant=%h exp=%h shift=%0d u%b d%b want 800000/3F6/15/u1/d0", out_mant, out_exp, out_shift, out_uflow, out_denorm); end
        ack();
        do_op(24'h000100, 8'd0, lat);
        n_checks++; if ({out_mant, out_exp, out_shift, out_uflow, out_denorm} !== {24'h800000, 10'h3F1, 5'd15, 2'b10}) begin
            n_errors++; $display("FAIL uflow_exp0: got mant=%h exp=%h shift=%0d u%b d%b want 800000/3F1/15/u1/d0", out_mant, out_exp, out_shift, out_uflow, out_denorm); end
`endif
        ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad;
        do_op(24'h0F0000, 8'd127, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_mant === 24'hF00000 &&
                  out_exp === 10'd123 && out_shift === 5'd4)) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL backpressure_hold: %0d of 10 cycles changed, want 0", bad); end
        ack();
        n_checks++; if ({in_ready, out_valid} !== 2'b10) begin
            n_errors++; $display("FAIL release_ready: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        do_op(24'h000001, 8'd100, lat);
        n_checks++; if (lat !== 5) begin n_errors++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        n_checks++; if ({out_mant, out_exp, out_shift} !== {24'h800000, 10'd77, 5'd23}) begin
            n_errors++; $display("FAIL b2b_result: got mant=%h exp=%0d shift=%0d want 800000/77/23", out_mant, out_exp, out_shift); end
        ack();
    endtask

    task automatic test_reset_abort();
        int lat;
        int bad;
        in_mant  = 24'h000001;
        in_exp   = 8'd100;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_checks++; if ({in_ready, out_valid, out_mant, out_exp, out_shift, out_zero, out_uflow, out_denorm} !== 45'd0) begin
            n_errors++; $display("FAIL abort_outputs: ready=%b valid=%b mant=%h exp=%h shift=%0d want all 0", in_ready, out_valid, out_mant, out_exp, out_shift); end
        tick();
        #2 rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_errors++; $display("FAIL abort_no_result: %0d cycles with stray valid/ready, want 0", bad); end
        do_op(24'h0F0000, 8'd127, lat);
        n_checks++; if (lat !== 5) begin n_errors++; $display("FAIL abort_next_latency: got %0d want 5", lat); end
        n_checks++; if ({out_mant, out_exp, out_shift, out_zero, out_uflow} !== {24'hF00000, 10'd123, 5'd4, 2'b00}) begin
            n_errors++; $display("FAIL abort_next_result: got mant=%h exp=%0d shift=%0d z%b u%b want F00000/123/4/0/0", out_mant, out_exp, out_shift, out_zero, out_uflow); end
        ack();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_mant   = '0;
        in_exp    = '0;
        out_ready = 1'b0;
        test_reset();
        test_full_shift();
        test_no_shift();
        test_zero();
        test_uflow();
        test_back_to_back();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
